// File: rtl/fader_pkg.sv
// Shared types and defaults for the fader stimulus sequencer.
// Optional channel checker is built when FADER_STIM_SEQ_CHK_EN is defined.
package fader_pkg;

  localparam int unsigned NCHAN_DEFAULT  = 32;
  localparam int unsigned CHAN_W_DEFAULT = $clog2(NCHAN_DEFAULT);

  typedef enum logic [1:0] {
    MODE_FREE  = 2'd0,
    MODE_BURST = 2'd1,
    MODE_STEP  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/fader_stim_seq_if.sv
// Control, fader-return and status bundle of the stimulus sequencer.
// The master side drives control and the fader stream; the slave is the sequencer.
interface fader_stim_seq_if #(
    parameter int unsigned TIDX_W   = 25,
    parameter int unsigned PERIOD_W = 10,
    parameter int unsigned CHAN_W   = 5,
    parameter int unsigned BURST_W  = 16
);

    logic                enable;
    logic [1:0]          mode;
    logic                arm;
    logic [PERIOD_W-1:0] period;
    logic [BURST_W-1:0]  burst_len;
    logic [TIDX_W-1:0]   tidx_step;
    logic [TIDX_W-1:0]   tidx_base;
    logic                dv_in;
    logic [CHAN_W-1:0]   chan_in;
    logic                start;
    logic [TIDX_W-1:0]   t_index;
    logic                busy;
    logic                done;
    logic                overrun;
    logic [BURST_W-1:0]  frame_count;
    logic                chan_err;

    modport master (
        output enable, mode, arm, period, burst_len, tidx_step, tidx_base, dv_in, chan_in,
        input  start, t_index, busy, done, overrun, frame_count, chan_err
    );

    modport slave (
        input  enable, mode, arm, period, burst_len, tidx_step, tidx_base, dv_in, chan_in,
        output start, t_index, busy, done, overrun, frame_count, chan_err
    );

endinterface

// File: rtl/fader_frame_mon.sv
// Watches the fader output stream: beat/frame counting, overrun detection and,
// when FADER_STIM_SEQ_CHK_EN is defined, a channel-order checker.
module fader_frame_mon #(
    parameter int unsigned NCHAN   = 32,
    parameter int unsigned CHAN_W  = 5,
    parameter int unsigned BURST_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_i,
    input  logic               abort_i,
    input  logic               start_i,
    input  logic               dv_i,
    input  logic [CHAN_W-1:0]  chan_i,
    output logic               active_o,
    output logic               idle_o,
    output logic [BURST_W-1:0] frame_count_o,
    output logic               overrun_o,
    output logic               chan_err_o
);

    localparam logic [CHAN_W-1:0] LastBeat = CHAN_W'(NCHAN - 1);

    logic [CHAN_W-1:0]  beat_q, beat_d;
    logic [BURST_W-1:0] frames_q, frames_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;

    always_comb begin
        beat_d    = beat_q;
        frames_d  = frames_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (dv_i) begin
            pending_d = 1'b0;
            if (beat_q == LastBeat) begin
                beat_d   = '0;
                frames_d = frames_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
        // A beat coinciding with a start belongs to the earlier frame.
        if (start_i) begin
            pending_d = 1'b1;
            if (beat_q != '0 || pending_q) overrun_d = 1'b1;
        end
        if (abort_i) begin
            beat_d    = '0;
            pending_d = 1'b0;
        end
        if (clear_i) begin
            frames_d  = '0;
            overrun_d = 1'b0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q    <= '0;
            frames_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            frames_q  <= frames_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign active_o      = (beat_q != '0);
    assign idle_o        = (beat_q == '0) && !pending_q;
    assign frame_count_o = frames_q;
    assign overrun_o     = overrun_q;

`ifdef FADER_STIM_SEQ_CHK_EN
    logic [CHAN_W-1:0] exp_q, exp_d;
    logic              err_q, err_d;
    logic [CHAN_W-1:0] ref_chan;

    always_comb begin
        exp_d    = exp_q;
        err_d    = err_q;
        ref_chan = exp_q;
        if (dv_i) begin
            // On mismatch, follow the fader's numbering from here on.
            if (chan_i != exp_q) begin
                err_d    = 1'b1;
                ref_chan = chan_i;
            end
            exp_d = (ref_chan == LastBeat || beat_q == LastBeat) ? '0 : ref_chan + 1'b1;
        end
        if (abort_i) exp_d = '0;
        if (clear_i) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign chan_err_o = err_q;
`else
    logic unused_chan;
    assign unused_chan = ^chan_i;
    assign chan_err_o  = 1'b0;
`endif

endmodule

// File: rtl/fader_stim_seq.sv
// Start-pulse / t_index sequencer for the fader core (free-run, burst, single-step).
// FADER_STIM_SEQ_CHK_EN enables the channel-order checker in the frame monitor.
module fader_stim_seq
    import fader_pkg::*;
#(
    parameter int unsigned TIDX_W   = 25,
    parameter int unsigned PERIOD_W = 10,
    parameter int unsigned NCHAN    = NCHAN_DEFAULT,
    parameter int unsigned CHAN_W   = CHAN_W_DEFAULT,
    parameter int unsigned BURST_W  = 16
) (
    input logic             clk,
    input logic             reset_n,
    fader_stim_seq_if.slave bus
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [BURST_W-1:0]  starts_q, starts_d;
    logic [TIDX_W-1:0]   step_q, step_d;
    logic [TIDX_W-1:0]   tidx_q, tidx_d;
    logic [BURST_W-1:0]  starts_nxt;

    logic start, done, clear, abort;
    logic mon_active, mon_idle;

    assign starts_nxt = starts_q + 1'b1;
    assign abort      = !bus.enable && (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        burst_d  = burst_q;
        starts_d = starts_q;
        step_d   = step_q;
        tidx_d   = tidx_q;
        start    = 1'b0;
        done     = 1'b0;
        clear    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.enable && bus.arm) begin
                    unique case (bus.mode)
                        2'd0:    mode_d = MODE_FREE;
                        2'd1:    mode_d = MODE_BURST;
                        default: mode_d = MODE_STEP;
                    endcase
                    period_d = bus.period;
                    cnt_d    = bus.period;
                    burst_d  = bus.burst_len;
                    step_d   = bus.tidx_step;
                    tidx_d   = bus.tidx_base;
                    starts_d = '0;
                    clear    = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (mode_q == MODE_BURST && burst_q == '0) begin
                    state_d = StDrain;
                end else if (cnt_q == '0) begin
                    // t_index moves on after the start so it is stable during the pulse.
                    start    = 1'b1;
                    cnt_d    = period_q;
                    starts_d = starts_nxt;
                    tidx_d   = tidx_q + step_q;
                    if (mode_q == MODE_STEP || (mode_q == MODE_BURST && starts_nxt == burst_q)) begin
                        state_d = StDrain;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDrain: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (mon_idle) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            mode_q   <= MODE_FREE;
            period_q <= '0;
            cnt_q    <= '0;
            burst_q  <= '0;
            starts_q <= '0;
            step_q   <= '0;
            tidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            burst_q  <= burst_d;
            starts_q <= starts_d;
            step_q   <= step_d;
            tidx_q   <= tidx_d;
        end
    end

    fader_frame_mon #(
        .NCHAN   (NCHAN),
        .CHAN_W  (CHAN_W),
        .BURST_W (BURST_W)
    ) u_frame_mon (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_i       (clear),
        .abort_i       (abort),
        .start_i       (start),
        .dv_i          (bus.dv_in),
        .chan_i        (bus.chan_in),
        .active_o      (mon_active),
        .idle_o        (mon_idle),
        .frame_count_o (bus.frame_count),
        .overrun_o     (bus.overrun),
        .chan_err_o    (bus.chan_err)
    );

    assign bus.start   = start;
    assign bus.done    = done;
    assign bus.t_index = tidx_q;
    assign bus.busy    = (state_q != StIdle) || mon_active;

endmodule

// File: doc/fader_stim_seq.md
Name: fader_stim_seq

Overview:
- Parametrised start-pulse and time-index sequencer that drives the fader core in hardware test and system builds.
- Generates start pulses at a programmable period and advances t_index by a programmable step.
- Supports free-run, burst and single-step modes.
- Monitors the fader's dv_out/chan_out stream to count completed frames and flag overruns.

Parameters:
- TIDX_W, 25, t_index width
- PERIOD_W, 10, period register width
- NCHAN, 32, channel beats per fader frame
- CHAN_W, 5, chan_in width (clog2 NCHAN)
- BURST_W, 16, burst length and frame counter width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; low aborts any activity and forces IDLE
- mode  in  2  0=FREE, 1=BURST, 2=STEP, 3=reserved (treated as STEP)
- arm  in  1  one-cycle pulse; starts a sequence from IDLE and clears sticky flags
- period  in  PERIOD_W  start spacing minus 1, sampled on arm
- burst_len  in  BURST_W  number of starts in BURST, sampled on arm
- tidx_step  in  TIDX_W  t_index increment per start, sampled on arm
- tidx_base  in  TIDX_W  t_index for first start, loaded on arm
- dv_in  in  1  fader dv_out
- chan_in  in  CHAN_W  fader chan_out
- start  out  1  one-cycle start pulse to fader
- t_index  out  TIDX_W  time index; stable while start is high
- busy  out  1  state != IDLE or a frame is partially received
- done  out  1  one-cycle pulse at end of a BURST/STEP sequence
- overrun  out  1  sticky flag
- frame_count  out  BURST_W  completed frames since arm, wraps
- chan_err  out  1  sticky flag, only with macro enabled (tied 0 otherwise)

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- States:
  - IDLE: wait for arm with enable high; on arm, latch parameters, load t_index=tidx_base and down-counter=period, clear overrun/chan_err/frame_count, go to RUN.
  - RUN: counter decrements each cycle. At counter==0: start=1 for that cycle, counter reloads period, and the start count increments. t_index advances by tidx_step (mod 2^TIDX_W) on the cycle after start.
  - DRAIN: all required starts issued; wait for the frame to complete, then pulse done and go to IDLE.
- Timing: first start occurs exactly period+1 cycles after the arm cycle; subsequent starts every period+1 cycles. period=0 gives start every cycle. k-th start (k from 0) carries tidx_base + k*tidx_step.
- Mode exit conditions:
  - FREE: stays in RUN until enable goes low; never pulses done.
  - BURST: after burst_len starts, go to DRAIN.
  - STEP: one start, then DRAIN.
  - burst_len=0: go straight to DRAIN; done pulses 2 cycles after arm, no start.
- Frame monitor:
  - Beat counter increments on dv_in.
  - On reaching NCHAN beats, frame_count increments and the beat counter clears.
  - dv_in is counted in any state.
- Overrun: set if start fires while the beat counter !=0, or while the previous start's frame has not yet begun (pending flag). This is the fader-not-keeping-up condition. The start is still issued.
- arm outside IDLE: ignored.
- Simultaneous arm and enable low: enable wins, stays IDLE.
- enable low in RUN/DRAIN: IDLE at next edge, no done, beat counter cleared, flags held.
- Async reset mid-operation clears everything immediately; no start is emitted until a new arm.

Optional Feature:
- Macro FADER_STIM_SEQ_CHK_EN.
- With it defined: chan_in is checked on every dv_in against an expected-channel counter (0..NCHAN-1, resets per frame). A mismatch sets chan_err (sticky, cleared by arm) and resynchronises expected to chan_in+1.
- Without it: checker logic is absent and chan_err is tied 0.

Decomposition:
- Shared package fader_pkg holds:
  - mode enum (MODE_FREE, MODE_BURST, MODE_STEP)
  - state enum
  - NCHAN default and derived CHAN_W
- One natural sub-module: fader_frame_mon, containing the beat counter, frame_count, pending/overrun detection and the optional channel checker. The top level holds the FSM, period counter and t_index.

Test Plan:
- STEP, period=9, tidx_base=100, step=3, arm -> single start 10 cycles after arm with t_index=100; after 32 dv_in beats, done pulses once; frame_count=1.
- BURST, period=4, burst_len=4, base=0, step=5 -> starts at 5-cycle spacing with t_index 0,5,10,15; done only after the 4th frame completes; frame_count=4; overrun=0.
- FREE, period=0, fader model slower than 1 frame/cycle -> start every cycle; overrun set on 2nd start and held until the next arm.
- t_index wrap: base=2^25-2, step=3, burst_len=2 -> t_index 2^25-2 then 1.
- enable dropped mid-BURST after 2 starts -> IDLE next cycle, no further start, no done; reset_n low mid-run clears all outputs asynchronously.
- With FADER_STIM_SEQ_CHK_EN, chan_in sequence 0,1,3 -> chan_err=1 on the third beat; sticky until arm; without the macro, chan_err stays 0.
